// File: rtl/branch_redirect_controller.sv
// Compares resolved EX branch/jump outcome with the fetch prediction and, on a
// mismatch, holds a redirect to fetch, stalls EX and squashes younger work.
module branch_redirect_controller #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_ex_valid,
  input  logic             i_stall,
  input  logic             i_is_branch,
  input  logic             i_is_jal,
  input  logic             i_is_jalr,
  input  logic             i_branch_taken,
  input  logic [XLEN-1:0]  i_branch_target,
  input  logic [XLEN-1:0]  i_fallthrough_pc,
  input  logic             i_pred_taken,
  input  logic [XLEN-1:0]  i_pred_target,
  input  logic             i_redirect_ready,
  output logic             o_redirect_valid,
  output logic [XLEN-1:0]  o_redirect_pc,
  output logic             o_flush,
  output logic             o_ex_stall,
  output logic             o_target_misaligned,
  output logic [CNT_W-1:0] o_branch_count,
  output logic [CNT_W-1:0] o_mispredict_count
);

  // state    | meaning
  // IDLE     | evaluating EX each cycle
  // REDIRECT | corrected PC offered to fetch, waiting for ready
  // FLUSH    | post-handshake squash window, flush_cnt counts down to 0
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  localparam logic [3:0] FLUSH_LOAD = (FLUSH_CYCLES > 0) ? 4'(FLUSH_CYCLES - 1) : 4'd0;

  state_t          state;
  logic [3:0]      flush_cnt;
  logic            is_ctrl;
  logic            taken;
  logic            eval;
  logic            misal;
  logic            mis;
  logic [XLEN-1:0] correct_pc;

  // Jumps are unconditionally taken regardless of the resolution flag.
  assign is_ctrl    = i_is_branch | i_is_jal | i_is_jalr;
  assign taken      = i_branch_taken | i_is_jal | i_is_jalr;
  assign eval       = i_ex_valid & ~i_stall & is_ctrl & (state == IDLE);
  assign misal      = eval & taken & (i_branch_target[1:0] != 2'b00);
  assign mis        = eval & ~misal &
                      ((taken != i_pred_taken) | (taken & (i_pred_target != i_branch_target)));
  assign correct_pc = taken ? i_branch_target : i_fallthrough_pc;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state               <= IDLE;
      flush_cnt           <= 4'd0;
      o_redirect_pc       <= '0;
      o_target_misaligned <= 1'b0;
      o_branch_count      <= '0;
      o_mispredict_count  <= '0;
    end else begin
      o_target_misaligned <= misal;
      if (eval && (o_branch_count != '1))
        o_branch_count <= o_branch_count + CNT_W'(1);
      if (mis && (o_mispredict_count != '1))
        o_mispredict_count <= o_mispredict_count + CNT_W'(1);

      case (state)
        IDLE: begin
          if (mis) begin
            state         <= REDIRECT;
            o_redirect_pc <= correct_pc;
          end
        end
        REDIRECT: begin
          if (i_redirect_ready) begin
            if (FLUSH_CYCLES > 0) begin
              state     <= FLUSH;
              flush_cnt <= FLUSH_LOAD;
            end else begin
              state <= IDLE;
            end
          end
        end
        FLUSH: begin
          if (flush_cnt == 4'd0) state <= IDLE;
          else                   flush_cnt <= flush_cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_redirect_valid = (state == REDIRECT);
  assign o_flush          = (state == REDIRECT) | (state == FLUSH);
  assign o_ex_stall       = o_flush;

endmodule

// File: tb/tb_branch_redirect_controller.sv
// Self-checking bench: table of single-instruction evaluations checked through
// a scoreboard queue, plus hand sequences for handshake, flush, reset, saturation.
module tb_branch_redirect_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, stall, is_branch, is_jal, is_jalr, taken;
  logic [31:0] target, ft, pred_target;
  logic        pred_taken, ready;

  logic        a_valid, a_flush, a_stall, a_misal;
  logic [31:0] a_pc, a_bc, a_mc;
  logic        b_valid, b_flush, b_stall, b_misal;
  logic [31:0] b_pc;
  logic [3:0]  b_bc, b_mc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_redirect_controller #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_W(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ex_valid(ex_valid), .i_stall(stall),
    .i_is_branch(is_branch), .i_is_jal(is_jal), .i_is_jalr(is_jalr),
    .i_branch_taken(taken), .i_branch_target(target), .i_fallthrough_pc(ft),
    .i_pred_taken(pred_taken), .i_pred_target(pred_target), .i_redirect_ready(ready),
    .o_redirect_valid(a_valid), .o_redirect_pc(a_pc), .o_flush(a_flush),
    .o_ex_stall(a_stall), .o_target_misaligned(a_misal),
    .o_branch_count(a_bc), .o_mispredict_count(a_mc)
  );

  branch_redirect_controller #(.XLEN(32), .FLUSH_CYCLES(0), .CNT_W(4)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_ex_valid(ex_valid), .i_stall(stall),
    .i_is_branch(is_branch), .i_is_jal(is_jal), .i_is_jalr(is_jalr),
    .i_branch_taken(taken), .i_branch_target(target), .i_fallthrough_pc(ft),
    .i_pred_taken(pred_taken), .i_pred_target(pred_target), .i_redirect_ready(ready),
    .o_redirect_valid(b_valid), .o_redirect_pc(b_pc), .o_flush(b_flush),
    .o_ex_stall(b_stall), .o_target_misaligned(b_misal),
    .o_branch_count(b_bc), .o_mispredict_count(b_mc)
  );

  typedef struct {
    logic        ex_valid, stall, is_branch, is_jal, is_jalr, taken;
    logic [31:0] target, ft;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        exp_eval, exp_misal, exp_mis;
    logic [31:0] exp_pc;
  } vec_t;

  typedef struct {
    logic        eval, misal, mis;
    logic [31:0] pc;
  } exp_t;

  vec_t vecs[13];
  exp_t sb[$];

  function automatic vec_t mk(logic v, logic s, logic br, logic jal, logic jalr, logic tk,
                              logic [31:0] tg, logic [31:0] f, logic pt, logic [31:0] ptg,
                              logic ev, logic ma, logic mi, logic [31:0] pc);
    vec_t r;
    r.ex_valid = v;  r.stall = s;  r.is_branch = br; r.is_jal = jal; r.is_jalr = jalr;
    r.taken = tk;    r.target = tg; r.ft = f;         r.pred_taken = pt; r.pred_target = ptg;
    r.exp_eval = ev; r.exp_misal = ma; r.exp_mis = mi; r.exp_pc = pc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 0; stall = 0; is_branch = 0; is_jal = 0; is_jalr = 0; taken = 0;
    target = 0; ft = 0; pred_taken = 0; pred_target = 0; ready = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    step();
    step();
    rst_n = 1;
  endtask

  task automatic drive(input vec_t v);
    ex_valid = v.ex_valid; stall = v.stall; is_branch = v.is_branch; is_jal = v.is_jal;
    is_jalr = v.is_jalr; taken = v.taken; target = v.target; ft = v.ft;
    pred_taken = v.pred_taken; pred_target = v.pred_target;
  endtask

  initial begin
    exp_t e;
    //            v  s  br jal jalr tk target        ft            pt ptarget       ev ma mi pc
    vecs[0]  = mk(1, 0, 1, 0, 0, 1, 32'h0000_0100, 32'h0000_0004, 1, 32'h0000_0100, 1, 0, 0, 32'h0);
    vecs[1]  = mk(1, 0, 1, 0, 0, 0, 32'h0000_0300, 32'h0000_0204, 1, 32'h0000_0300, 1, 0, 1, 32'h0000_0204);
    vecs[2]  = mk(1, 0, 0, 0, 1, 1, 32'h0000_3000, 32'h0000_0010, 1, 32'h0000_2FF0, 1, 0, 1, 32'h0000_3000);
    vecs[3]  = mk(1, 0, 0, 1, 0, 1, 32'h0000_0102, 32'h0000_0020, 1, 32'h0000_0102, 1, 1, 0, 32'h0);
    vecs[4]  = mk(1, 0, 1, 0, 0, 0, 32'h0000_0200, 32'h0000_0108, 0, 32'h0000_0999, 1, 0, 0, 32'h0);
    vecs[5]  = mk(1, 0, 1, 0, 0, 1, 32'h0000_0400, 32'h0000_0010, 0, 32'h0000_0400, 1, 0, 1, 32'h0000_0400);
    vecs[6]  = mk(1, 1, 1, 0, 0, 1, 32'h0000_0400, 32'h0000_0010, 0, 32'h0000_0400, 0, 0, 0, 32'h0);
    vecs[7]  = mk(1, 0, 0, 0, 0, 1, 32'h0000_0400, 32'h0000_0010, 0, 32'h0000_0400, 0, 0, 0, 32'h0);
    vecs[8]  = mk(0, 0, 1, 0, 0, 1, 32'h0000_0400, 32'h0000_0010, 0, 32'h0000_0400, 0, 0, 0, 32'h0);
    vecs[9]  = mk(1, 0, 0, 1, 0, 1, 32'h0000_0800, 32'h0000_0040, 0, 32'h0000_0800, 1, 0, 1, 32'h0000_0800);
    vecs[10] = mk(1, 0, 1, 0, 0, 0, 32'h0000_0102, 32'h0000_0050, 0, 32'h0000_0000, 1, 0, 0, 32'h0);
    vecs[11] = mk(1, 0, 0, 1, 0, 1, 32'h0000_0500, 32'h0000_0060, 1, 32'h0000_0500, 1, 0, 0, 32'h0);
    vecs[12] = mk(1, 0, 1, 0, 0, 1, 32'h0000_0103, 32'h0000_0070, 0, 32'h0000_0000, 1, 1, 0, 32'h0);

    do_reset();
    chk("rst_valid", {31'b0, a_valid}, 32'h0);
    chk("rst_flush", {31'b0, a_flush}, 32'h0);
    chk("rst_stall", {31'b0, a_stall}, 32'h0);
    chk("rst_misal", {31'b0, a_misal}, 32'h0);
    chk("rst_pc",    a_pc, 32'h0);
    chk("rst_bc",    a_bc, 32'h0);
    chk("rst_mc",    a_mc, 32'h0);

    // Table: one instruction presented in IDLE, checked on the following cycle.
    for (int i = 0; i < 13; i++) begin
      do_reset();
      drive(vecs[i]);
      e.eval = vecs[i].exp_eval; e.misal = vecs[i].exp_misal;
      e.mis = vecs[i].exp_mis;   e.pc = vecs[i].exp_pc;
      sb.push_back(e);
      step();
      ex_valid = 0;
      e = sb.pop_front();
      chk($sformatf("v%0d_misal", i), {31'b0, a_misal}, {31'b0, e.misal});
      chk($sformatf("v%0d_valid", i), {31'b0, a_valid}, {31'b0, e.mis});
      chk($sformatf("v%0d_bvalid", i), {31'b0, b_valid}, {31'b0, e.mis});
      chk($sformatf("v%0d_pc", i), a_pc, e.pc);
      chk($sformatf("v%0d_bc", i), a_bc, {31'b0, e.eval});
      chk($sformatf("v%0d_mc", i), a_mc, {31'b0, e.mis});
      step();
      chk($sformatf("v%0d_pulse_end", i), {31'b0, a_misal}, 32'h0);
      chk($sformatf("v%0d_hold", i), {31'b0, a_valid}, {31'b0, e.mis});
    end

    // Not-taken mispredict, ready low 3 cycles; younger EX inputs must be ignored.
    do_reset();
    drive(vecs[1]);
    step();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("nt_valid%0d", i), {31'b0, a_valid}, 32'h1);
      chk($sformatf("nt_pc%0d", i), a_pc, 32'h0000_0204);
      chk($sformatf("nt_flush%0d", i), {31'b0, a_flush}, 32'h1);
      chk($sformatf("nt_stall%0d", i), {31'b0, a_stall}, 32'h1);
      drive(vecs[5]);
      ready = (i == 3);
    end_loop_step: step();
    end
    ready = 0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("nt_fvalid%0d", i), {31'b0, a_valid}, 32'h0);
      chk($sformatf("nt_fflush%0d", i), {31'b0, a_flush}, 32'h1);
      chk($sformatf("nt_fstall%0d", i), {31'b0, a_stall}, 32'h1);
      if (i == 1) ex_valid = 0;
      step();
    end
    chk("nt_idle_flush", {31'b0, a_flush}, 32'h0);
    chk("nt_idle_stall", {31'b0, a_stall}, 32'h0);
    chk("nt_bc", a_bc, 32'h1);
    chk("nt_mc", a_mc, 32'h1);

    // JALR wrong target, zero-wait handshake; FLUSH_CYCLES=0 returns to IDLE at once.
    do_reset();
    drive(vecs[2]);
    ready = 1;
    step();
    ex_valid = 0;
    chk("jalr_b_valid", {31'b0, b_valid}, 32'h1);
    chk("jalr_b_pc", b_pc, 32'h0000_3000);
    chk("jalr_a_pc", a_pc, 32'h0000_3000);
    step();
    chk("jalr_b_idle", {31'b0, b_flush}, 32'h0);
    chk("jalr_b_mc", {28'b0, b_mc}, 32'h1);
    chk("jalr_a_valid", {31'b0, a_valid}, 32'h0);
    chk("jalr_a_flush1", {31'b0, a_flush}, 32'h1);
    step();
    chk("jalr_a_flush2", {31'b0, a_flush}, 32'h1);
    step();
    chk("jalr_a_idle", {31'b0, a_flush}, 32'h0);

    // Reset during REDIRECT, then a fresh mispredict.
    do_reset();
    drive(vecs[1]);
    step();
    chk("rmid_in_redirect", {31'b0, a_valid}, 32'h1);
    rst_n = 0;
    ex_valid = 0;
    step();
    chk("rmid_valid", {31'b0, a_valid}, 32'h0);
    chk("rmid_flush", {31'b0, a_flush}, 32'h0);
    chk("rmid_pc", a_pc, 32'h0);
    chk("rmid_bc", a_bc, 32'h0);
    chk("rmid_mc", a_mc, 32'h0);
    rst_n = 1;
    drive(vecs[5]);
    ready = 1;
    step();
    ex_valid = 0;
    chk("rmid_re_valid", {31'b0, a_valid}, 32'h1);
    chk("rmid_re_pc", a_pc, 32'h0000_0400);
    chk("rmid_re_mc", a_mc, 32'h1);

    // Continuous mispredicts: 4-bit counters saturate, 32-bit ones keep counting.
    do_reset();
    drive(vecs[5]);
    ready = 1;
    repeat (60) step();
    ex_valid = 0;
    chk("sat_b_mc", {28'b0, b_mc}, 32'hF);
    chk("sat_b_bc", {28'b0, b_bc}, 32'hF);
    chk("sat_a_mc", a_mc, 32'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
